uart_tx_arbiter: RTL

Shares a single UART transmitter between NUM_PORTS byte sources using round-robin arbitration with per-packet locking. Each source presents bytes on a valid/ready handshake and marks message ends with a last flag. The block drives the transmitter's data/ok/busy interface and sequences exactly one byte per transmitter frame. It sits between the debug/console producers and the UART transmitter instance.

---
 rtl/uart_tx_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_PORTS byte sources.
// A packet (bytes up to and including last) keeps the grant unless its source stalls too long.
module uart_tx_arbiter #(
  parameter int          NUM_PORTS    = 4,
  parameter int unsigned LOCK_TIMEOUT = 1000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PORTS-1:0]         req_valid,
  input  logic [8*NUM_PORTS-1:0]       req_data,
  input  logic [NUM_PORTS-1:0]         req_last,
  output logic [NUM_PORTS-1:0]         req_ready,
  output logic [7:0]                   tx_data,
  output logic                         tx_ok,
  input  logic                         tx_busy,
  output logic [$clog2(NUM_PORTS)-1:0] grant_id,
  output logic                         locked
);

  localparam int              IDW       = $clog2(NUM_PORTS);
  localparam logic [IDW-1:0]  LAST_PORT = IDW'(NUM_PORTS - 1);
  localparam logic [31:0]     TO_LAST   = (LOCK_TIMEOUT > 0) ? 32'(LOCK_TIMEOUT - 1) : 32'd0;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [31:0]    idle_cnt;

  logic [IDW:0]   rr_result;
  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [7:0]     win_byte;
  logic           win_last;
  logic           accept;
  logic           stall;

  // Returns {found, id}: first valid port after ptr, wrapping; reverse scan so the nearest wins.
  function automatic logic [IDW:0] rr_pick(input logic [NUM_PORTS-1:0] valid,
                                           input logic [IDW-1:0]       ptr);
    logic [IDW:0]   res;
    logic [IDW-1:0] idx;
    res = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = IDW'((int'(ptr) + k) % NUM_PORTS);
      if (valid[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Saturating so a never-expiring lock cannot wrap the counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

  always_comb begin
    rr_result = rr_pick(req_valid, rr_ptr);
    if (locked) begin
      win_found = req_valid[grant_id];
      win_id    = grant_id;
    end else begin
      win_found = rr_result[IDW];
      win_id    = rr_result[IDW-1:0];
    end
    win_byte = '0;
    win_last = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (win_id == IDW'(i)) begin
        win_byte = req_data[8*i +: 8];
        win_last = req_last[i];
      end
    end
  end

  assign accept = (state == IDLE) && win_found && !reset;
  assign stall  = (state == IDLE) && locked && !req_valid[grant_id];

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win_id] = 1'b1;
  end

  // The start strobe must react to tx_busy in the same cycle to keep the one-cycle latency.
  assign tx_ok = (state == ISSUE) && !tx_busy && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx_data  <= '0;
      grant_id <= '0;
      locked   <= 1'b0;
      rr_ptr   <= LAST_PORT;
      idle_cnt <= '0;
    end else begin
      if (!locked) idle_cnt <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            tx_data  <= win_byte;
            grant_id <= win_id;
            rr_ptr   <= win_id;
            locked   <= !win_last;
            idle_cnt <= '0;
            state    <= ISSUE;
          end else if (stall) begin
            if (LOCK_TIMEOUT != 0 && idle_cnt == TO_LAST) begin
              locked   <= 1'b0;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= sat_inc(idle_cnt);
            end
          end
        end
        ISSUE: begin
          if (!tx_busy) state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
